// File: rtl/serial_uart_port.sv
// Device-side UART endpoint: processor byte interface with TX/RX FIFOs and 8N1
// serializer/deserializer on uart_tx_out/uart_rx_in.
module serial_uart_port #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned FIFO_DEPTH   = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] proc_wdata_in,
    input  logic       proc_wren_in,
    input  logic       proc_rden_in,
    output logic [7:0] proc_rdata_out,
    output logic       proc_valid_out,
    output logic       proc_ready_out,
    input  logic       proc_clr_err_in,
    input  logic       uart_rx_in,
    output logic       uart_tx_out,
    output logic       rx_overrun_out,
    output logic       rx_frame_err_out
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam logic [AW:0]   FULL_CNT     = (AW+1)'(FIFO_DEPTH);
    localparam logic [CW-1:0] BIT_LAST     = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] START_SAMPLE = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {T_IDLE, T_START, T_DATA, T_STOP} tx_state_t;
    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;

    // ---------------- TX FIFO ----------------
    logic [7:0]    tx_mem [FIFO_DEPTH];
    logic [AW-1:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
    logic [AW:0]   tx_cnt_q, tx_cnt_d;
    logic          tx_full, tx_empty, tx_push, tx_pop;

    tx_state_t     tx_state_q;
    logic [CW-1:0] tx_baud_q;
    logic [2:0]    tx_bit_q;
    logic [7:0]    tx_shift_q;
    logic          tx_line_q;
    logic          tx_bit_end;

    assign tx_full    = (tx_cnt_q == FULL_CNT);
    assign tx_empty   = (tx_cnt_q == '0);
    assign tx_push    = proc_wren_in && !tx_full;
    assign tx_bit_end = (tx_baud_q == BIT_LAST);
    // Pop either from idle or right at the end of a stop bit, so queued bytes go out back-to-back.
    assign tx_pop     = !tx_empty && ((tx_state_q == T_IDLE) || ((tx_state_q == T_STOP) && tx_bit_end));

    always_comb begin
        tx_wr_d  = tx_wr_q;
        tx_rd_d  = tx_rd_q;
        tx_cnt_d = tx_cnt_q;
        if (tx_push) tx_wr_d = tx_wr_q + AW'(1);
        if (tx_pop)  tx_rd_d = tx_rd_q + AW'(1);
        if (tx_push && !tx_pop)      tx_cnt_d = tx_cnt_q + (AW+1)'(1);
        else if (!tx_push && tx_pop) tx_cnt_d = tx_cnt_q - (AW+1)'(1);
    end

    always_ff @(posedge clock) begin
        if (tx_push) tx_mem[tx_wr_q] <= proc_wdata_in;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tx_wr_q  <= '0;
            tx_rd_q  <= '0;
            tx_cnt_q <= '0;
        end else begin
            tx_wr_q  <= tx_wr_d;
            tx_rd_q  <= tx_rd_d;
            tx_cnt_q <= tx_cnt_d;
        end
    end

    // ---------------- TX FSM ----------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tx_state_q <= T_IDLE;
            tx_baud_q  <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_line_q  <= 1'b1;
        end else begin
            case (tx_state_q)
                T_IDLE: begin
                    if (tx_pop) begin
                        tx_shift_q <= tx_mem[tx_rd_q];
                        tx_line_q  <= 1'b0;
                        tx_baud_q  <= '0;
                        tx_state_q <= T_START;
                    end
                end
                T_START: begin
                    if (tx_bit_end) begin
                        tx_baud_q  <= '0;
                        tx_bit_q   <= '0;
                        tx_line_q  <= tx_shift_q[0];
                        tx_state_q <= T_DATA;
                    end else begin
                        tx_baud_q <= tx_baud_q + CW'(1);
                    end
                end
                T_DATA: begin
                    if (tx_bit_end) begin
                        tx_baud_q <= '0;
                        if (tx_bit_q == 3'd7) begin
                            tx_line_q  <= 1'b1;
                            tx_state_q <= T_STOP;
                        end else begin
                            tx_shift_q <= {1'b0, tx_shift_q[7:1]};
                            tx_line_q  <= tx_shift_q[1];
                            tx_bit_q   <= tx_bit_q + 3'd1;
                        end
                    end else begin
                        tx_baud_q <= tx_baud_q + CW'(1);
                    end
                end
                default: begin
                    if (tx_bit_end) begin
                        tx_baud_q <= '0;
                        if (tx_pop) begin
                            tx_shift_q <= tx_mem[tx_rd_q];
                            tx_line_q  <= 1'b0;
                            tx_state_q <= T_START;
                        end else begin
                            tx_state_q <= T_IDLE;
                        end
                    end else begin
                        tx_baud_q <= tx_baud_q + CW'(1);
                    end
                end
            endcase
        end
    end

    assign uart_tx_out    = tx_line_q;
    assign proc_ready_out = !tx_full;

    // ---------------- RX FIFO ----------------
    logic [7:0]    rx_mem [FIFO_DEPTH];
    logic [AW-1:0] rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
    logic [AW:0]   rx_cnt_q, rx_cnt_d;
    logic          rx_full, rx_empty, rx_push, rx_pop;

    rx_state_t     rx_state_q;
    logic [CW-1:0] rx_baud_q;
    logic [2:0]    rx_bit_q;
    logic [7:0]    rx_shift_q;
    logic          rx_meta_q, rx_sync_q, rx_prev_q;
    logic          rx_stop_sample, rx_overrun_set, rx_frame_set;
    logic          overrun_q, overrun_d, frame_err_q, frame_err_d;

    assign rx_full        = (rx_cnt_q == FULL_CNT);
    assign rx_empty       = (rx_cnt_q == '0);
    assign rx_pop         = proc_rden_in && !rx_empty;
    assign rx_stop_sample = (rx_state_q == R_STOP) && (rx_baud_q == BIT_LAST);
    // A full FIFO still takes the byte when the processor pops on the same edge.
    assign rx_push        = rx_stop_sample && rx_sync_q && (!rx_full || rx_pop);
    assign rx_overrun_set = rx_stop_sample && rx_sync_q && rx_full && !rx_pop;
    assign rx_frame_set   = rx_stop_sample && !rx_sync_q;

    always_comb begin
        rx_wr_d  = rx_wr_q;
        rx_rd_d  = rx_rd_q;
        rx_cnt_d = rx_cnt_q;
        if (rx_push) rx_wr_d = rx_wr_q + AW'(1);
        if (rx_pop)  rx_rd_d = rx_rd_q + AW'(1);
        if (rx_push && !rx_pop)      rx_cnt_d = rx_cnt_q + (AW+1)'(1);
        else if (!rx_push && rx_pop) rx_cnt_d = rx_cnt_q - (AW+1)'(1);
        overrun_d   = rx_overrun_set ? 1'b1 : (proc_clr_err_in ? 1'b0 : overrun_q);
        frame_err_d = rx_frame_set   ? 1'b1 : (proc_clr_err_in ? 1'b0 : frame_err_q);
    end

    always_ff @(posedge clock) begin
        if (rx_push) rx_mem[rx_wr_q] <= rx_shift_q;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rx_wr_q     <= '0;
            rx_rd_q     <= '0;
            rx_cnt_q    <= '0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
            rx_meta_q   <= 1'b1;
            rx_sync_q   <= 1'b1;
            rx_prev_q   <= 1'b1;
        end else begin
            rx_wr_q     <= rx_wr_d;
            rx_rd_q     <= rx_rd_d;
            rx_cnt_q    <= rx_cnt_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
            rx_meta_q   <= uart_rx_in;
            rx_sync_q   <= rx_meta_q;
            rx_prev_q   <= rx_sync_q;
        end
    end

    // ---------------- RX FSM ----------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rx_state_q <= R_IDLE;
            rx_baud_q  <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
        end else begin
            case (rx_state_q)
                R_IDLE: begin
                    if (rx_prev_q && !rx_sync_q) begin
                        rx_baud_q  <= '0;
                        rx_state_q <= R_START;
                    end
                end
                R_START: begin
                    if (rx_baud_q == START_SAMPLE) begin
                        rx_baud_q  <= '0;
                        rx_bit_q   <= '0;
                        rx_state_q <= rx_sync_q ? R_IDLE : R_DATA;
                    end else begin
                        rx_baud_q <= rx_baud_q + CW'(1);
                    end
                end
                R_DATA: begin
                    if (rx_baud_q == BIT_LAST) begin
                        rx_baud_q  <= '0;
                        rx_shift_q <= {rx_sync_q, rx_shift_q[7:1]};
                        if (rx_bit_q == 3'd7) rx_state_q <= R_STOP;
                        else                  rx_bit_q   <= rx_bit_q + 3'd1;
                    end else begin
                        rx_baud_q <= rx_baud_q + CW'(1);
                    end
                end
                default: begin
                    if (rx_stop_sample) begin
                        rx_baud_q  <= '0;
                        rx_state_q <= R_IDLE;
                    end else begin
                        rx_baud_q <= rx_baud_q + CW'(1);
                    end
                end
            endcase
        end
    end

    assign proc_valid_out   = !rx_empty;
    assign proc_rdata_out   = rx_empty ? '0 : rx_mem[rx_rd_q];
    assign rx_overrun_out   = overrun_q;
    assign rx_frame_err_out = frame_err_q;

endmodule
